// File: rtl/l1_dcache_pkg.sv
// l1_dcache_pkg: state encoding, geometry and address field positions shared with the L2 stage
package l1_dcache_pkg;
    typedef enum logic [1:0] {
        COMPARE   = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;
    localparam int BLOCK_NUM   = 8;
    localparam int WORDPERDATA = 4;
    localparam int ADDR_W      = 30;
    localparam int OFF_LSB     = 0;
    localparam int IDX_LSB     = $clog2(WORDPERDATA);
    localparam int TAG_LSB     = IDX_LSB + $clog2(BLOCK_NUM);
    localparam int LINE_W      = 32 * WORDPERDATA;
endpackage

// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped, write-back, write-allocate L1 data cache with zero-latency hits
module l1_dcache
    import l1_dcache_pkg::*;
#(
    parameter int BLOCK_NUM   = l1_dcache_pkg::BLOCK_NUM,
    parameter int WORDPERDATA = l1_dcache_pkg::WORDPERDATA,
    parameter int TAGLEN      = ADDR_W - $clog2(WORDPERDATA) - $clog2(BLOCK_NUM)
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);
    localparam int IW = $clog2(BLOCK_NUM);
    localparam int OW = $clog2(WORDPERDATA);
    localparam int SW = OW + 5;

    state_t              state_q, state_d;
    logic [127:0]        data_q [BLOCK_NUM];
    logic [127:0]        data_d [BLOCK_NUM];
    logic [TAGLEN-1:0]   tag_q [BLOCK_NUM];
    logic [TAGLEN-1:0]   tag_d [BLOCK_NUM];
    logic [BLOCK_NUM-1:0] valid_q, valid_d, dirty_q, dirty_d;

    logic [IW-1:0]     idx;
    logic [OW-1:0]     off;
    logic [TAGLEN-1:0] tag_in;
    logic [SW-1:0]     wsel;
    logic              rd, wr, hit;

    assign idx    = proc_addr[IDX_LSB +: IW];
    assign off    = proc_addr[OFF_LSB +: OW];
    assign tag_in = proc_addr[TAG_LSB +: TAGLEN];
    assign wsel   = {off, 5'd0};
    // A simultaneous read and write is served as a plain read
    assign rd     = proc_read;
    assign wr     = proc_write && !proc_read;
    assign hit    = valid_q[idx] && tag_q[idx] == tag_in;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        tag_d      = tag_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        proc_stall = 1'b0;
        proc_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            COMPARE: begin
                if ((rd || wr) && hit) begin
                    proc_rdata = rd ? data_q[idx][wsel +: 32] : '0;
                    if (wr) begin
                        data_d[idx][wsel +: 32] = proc_wdata;
                        dirty_d[idx]            = 1'b1;
                    end
                end else if (rd || wr) begin
                    proc_stall = 1'b1;
                    state_d    = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {tag_q[idx], idx};
                mem_wdata  = data_q[idx];
                state_d    = mem_ready ? ALLOCATE : WRITEBACK;
            end
            ALLOCATE: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                mem_addr   = proc_addr[29:2];
                if (mem_ready) begin
                    data_d[idx]  = mem_rdata;
                    tag_d[idx]   = tag_in;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    state_d      = COMPARE;
                end
            end
            default: state_d = COMPARE;
        endcase
    end

    // Reset drops any in-flight transaction; tag and data arrays keep their contents
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q <= COMPARE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end
endmodule

// File: doc/l1_dcache.md
L1_DCACHE -- requirements
Module: l1_dcache

Interface
REQ-001 Parameter BLOCK_NUM, 8, number of direct-mapped lines SHALL be supported.
REQ-002 Parameter WORDPERDATA, 4, 32-bit words per line SHALL be supported.
REQ-003 Parameter TAGLEN, 25, tag width = 30 - log2(WORDPERDATA) - log2(BLOCK_NUM) SHALL be used.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on posedge.
REQ-005 proc_reset  input  1  SHALL be a synchronous, active-high reset.
REQ-006 proc_read, proc_write  input  1 each  SHALL be the processor word read/write requests.
REQ-007 proc_addr  input  30  SHALL be the word address: [1:0] word offset, [4:2] index, [29:5] tag.
REQ-008 proc_wdata  input  32 / proc_rdata  output  32  SHALL be the processor write/read data.
REQ-009 proc_stall  output  1  SHALL be high while a request cannot complete this cycle.
REQ-010 mem_read, mem_write  output  1 each  SHALL be the line requests to the L2 stage.
REQ-011 mem_addr  output  28  SHALL be the line address to L2.
REQ-012 mem_wdata  output  128 / mem_rdata  input  128  SHALL carry whole lines, word 0 in bits [31:0].
REQ-013 mem_ready  input  1  SHALL be the one-cycle L2 completion pulse.

Function
REQ-014 Storage SHALL be BLOCK_NUM lines of 128 data bits, TAGLEN tag bits, 1 valid bit, 1 dirty bit; write-back, write-allocate.
REQ-015 FSM SHALL have states COMPARE, WRITEBACK, ALLOCATE; reset state COMPARE.
REQ-016 Hit SHALL be valid[index] && tag[index]==proc_addr[29:5], evaluated combinationally.
REQ-017 COMPARE, no request: proc_stall=0, no state change.
REQ-018 COMPARE, read hit: proc_stall=0 and proc_rdata=selected word in the same cycle (zero-latency).
REQ-019 COMPARE, write hit: proc_stall=0; word written and dirty set at the next posedge.
REQ-020 COMPARE, miss on a clean or invalid line: proc_stall=1, next state ALLOCATE.
REQ-021 COMPARE, miss on a valid dirty line: proc_stall=1, next state WRITEBACK.
REQ-022 WRITEBACK: mem_write=1, mem_addr={tag[index],index}, mem_wdata=line, all held constant until mem_ready; on mem_ready, next state ALLOCATE.
REQ-023 ALLOCATE: mem_read=1, mem_addr=proc_addr[29:2], held until mem_ready; on mem_ready, line:=mem_rdata, tag updated, valid=1, dirty=0, next state COMPARE.
REQ-024 After a refill, the request SHALL complete as a hit in COMPARE one cycle later; a write miss therefore merges into the refilled line and sets dirty.
REQ-025 proc_stall SHALL be 1 for every cycle spent in WRITEBACK or ALLOCATE.
REQ-026 mem_read and mem_write SHALL never be high simultaneously.
REQ-027 mem_ready outside WRITEBACK/ALLOCATE SHALL be ignored.
REQ-028 proc_read && proc_write together SHALL be treated as read only.
REQ-029 When idle, mem_addr and mem_wdata SHALL be 0 and proc_rdata SHALL be 0 when not a read hit.
REQ-030 Processor inputs SHALL be held stable by the processor while proc_stall=1; no behaviour is defined if they change.

Reset
REQ-031 proc_reset SHALL force state=COMPARE and clear all valid and dirty bits at the next posedge; tag/data contents need not be cleared.
REQ-032 During and after reset: proc_stall=0 (with no request), mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, proc_rdata=0.
REQ-033 Reset during WRITEBACK/ALLOCATE SHALL abort the transaction with no line update; a dirty line being written back is discarded.

Structure
REQ-034 A shared package SHALL hold the state encoding (COMPARE=0, WRITEBACK=1, ALLOCATE=2), BLOCK_NUM, WORDPERDATA, and the address field positions, shared with the L2 stage.
REQ-035 No sub-module SHALL be used; FSM, arrays and word select live in l1_dcache, with next-state/next-array combinational logic and one registered update block.

Verification
REQ-036 Reset, read 0x0000010 -> stall 1, mem_read=1 with mem_addr=0x0000004; mem_ready with mem_rdata={D3,D2,D1,D0} -> next cycle proc_rdata=D0, stall 0.
REQ-037 After REQ-036, read 0x0000013 -> stall 0 same cycle, proc_rdata=D3, no mem activity.
REQ-038 Write 0xDEADBEEF to 0x0000011 (hit) then read 0x0000011 -> 0xDEADBEEF, dirty set.
REQ-039 Read 0x0000031 (same index 4, new tag) -> mem_write=1, mem_addr=0x0000004, mem_wdata={D3,D2,0xDEADBEEF,D0}; after mem_ready, mem_read=1, mem_addr=0x000000C.
REQ-040 Assert proc_reset while in ALLOCATE with mem_read=1 -> next cycle mem_read=0, state COMPARE; re-reading 0x0000013 misses.
REQ-041 Random read/write stream vs. reference memory model with randomized mem_ready delay 0-10 cycles -> every proc_rdata matches and mem_read/mem_write never overlap.
